altitude_integrator: RTL
========================

Name: altitude_integrator

Overview:
- Downstream neighbour of the velocity stage. Consumes the per-clock velocity magnitude, the thrust direction and the burn-complete flag from that stage.
- Integrates vertical velocity into altitude each clock.
- After burnout, applies gravity deceleration itself, because the velocity stage holds velocity constant once ignition ends.
- Tracks flight phase, flags apogee, records peak altitude and detects landing. Feeds the angular-rate/trajectory stage.

Parameters:
- DT_US, 20, tick duration in microseconds (one clock = one integration step).
- GRAVITY, 9_799, gravitational acceleration in units of 1e-3 m/s^2.
- ACC_W, 128, width of the signed internal altitude accumulator.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset; one clock; sampled on rising clk
- start  input  1  launch request; honoured only in IDLE
- velocity  input  64  unsigned velocity magnitude from the velocity stage, units 1e-9 m/s
- backward  input  1  1 = the velocity stage is thrusting retrograde; magnitude taken as negative
- ignition_end  input  1  burn complete flag from the velocity stage
- altitude_mm  output  64  signed current altitude, millimetres
- max_altitude_mm  output  64  signed peak altitude latched at apogee, millimetres
- vert_velocity  output  64  signed internal vertical velocity, units 1e-9 m/s
- phase  output  3  0 IDLE, 1 BURN, 2 COAST, 3 DESCENT, 4 LANDED
- apogee  output  1  one-cycle pulse on the COAST->DESCENT transition
- landed  output  1  level; high while in LANDED

Behaviour:
- Reset values: all outputs 0; phase IDLE; accumulator acc = 0; internal velocity v = 0. Reset wins over every other event, in any state.
- Units:
  - acc is in 1e-15 m. Per-tick increment is v*DT_US.
  - altitude_mm = acc / 10^12, truncated toward zero and registered, so it lags acc by one clock.
  - Per-tick gravity decrement is DV = GRAVITY*DT_US, in 1e-9 m/s (195_980 at defaults).
- IDLE: acc and v held at 0. start=1 -> BURN on next edge. ignition_end is ignored in IDLE.
- BURN, each edge:
  - v <= backward ? -velocity : +velocity.
  - acc <= acc + v_new*DT_US, using the velocity sampled this edge, so there is no extra lag.
  - If the result is < 0, acc <= 0: no altitude below the pad while burning.
  - ignition_end=1 sampled -> COAST on the same edge. That edge's integration still uses the sampled velocity.
  - If ignition_end is already 1 on the first BURN edge, BURN lasts exactly one cycle.
- COAST, each edge:
  - v <= v - DV.
  - acc <= acc + (v - DV)*DT_US.
  - The velocity and backward inputs are ignored.
  - If (v - DV) <= 0: on that edge go to DESCENT, pulse apogee for the following cycle, and latch max_altitude_mm from the pre-update acc (truncated to mm).
- DESCENT, each edge:
  - v <= v - DV.
  - acc <= acc + (v - DV)*DT_US.
  - If the new acc <= 0: acc <= 0, v <= 0, go to LANDED.
- LANDED: all state frozen; landed=1; start is ignored. Only reset returns the block to IDLE.
- start while not in IDLE: ignored, no effect.
- ignition_end deasserting after COAST is entered: ignored. COAST never returns to BURN.
- Arithmetic:
  - velocity is zero-extended to 65 bits before negation.
  - v is held as 64-bit signed; input magnitude must be < 2^63, which is the caller's guarantee.
  - acc is ACC_W signed and does not saturate upward (adequate for >1e6 m at defaults).
  - altitude_mm is the low 64 bits of the quotient.
- Apogee fires at most once per flight.

Test Plan:
- Reset mid-COAST: drive reset=1 for one clk -> next cycle phase=0, altitude_mm=0, vert_velocity=0, apogee=0, landed=0. A start one cycle later re-enters BURN.
- Constant burn: start, velocity=100_000_000_000 (100 m/s), backward=0, ignition_end=0 for 1000 BURN cycles. -> acc grows 2 mm/tick; altitude_mm=2000 one cycle after the 1000th BURN edge; phase=1 throughout.
- Burnout and apogee: velocity=1_000_000_000 (1 m/s), ignition_end=1 on the first BURN edge. -> 1 BURN cycle, then COAST.
  - vert_velocity decreases by 195_980 per clock.
  - apogee pulses exactly once, after the 5103rd COAST edge.
  - vert_velocity is negative on entry to DESCENT; max_altitude_mm equals altitude at the pre-update acc.
- Full flight to landing: continue the previous run. -> altitude_mm decreases monotonically; phase goes to 4 the edge acc <= 0; altitude_mm=0, landed=1 and held for 100 further cycles despite start pulses.
- Retrograde burn from pad: backward=1, velocity=5_000_000_000 for 50 cycles. -> altitude_mm stays 0 (clamped); vert_velocity=-5_000_000_000; phase=1.
- Start ignored mid-flight: pulse start during COAST and DESCENT. -> no phase change; apogee count remains 1.

Source files
------------

// File: rtl/altitude_integrator.sv
// Altitude integrator: integrates vertical velocity into altitude, applies gravity
// after burnout, and tracks flight phase, apogee, peak altitude and landing.
module altitude_integrator #(
  parameter int DT_US   = 20,
  parameter int GRAVITY = 9_799,
  parameter int ACC_W   = 128
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [63:0]        velocity,
  input  logic               backward,
  input  logic               ignition_end,
  output logic signed [63:0] altitude_mm,
  output logic signed [63:0] max_altitude_mm,
  output logic signed [63:0] vert_velocity,
  output logic [2:0]         phase,
  output logic               apogee,
  output logic               landed
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    BURN    = 3'd1,
    COAST   = 3'd2,
    DESCENT = 3'd3,
    LANDED  = 3'd4
  } phase_t;

  // acc is in 1e-15 m, so one millimetre is 1e12 accumulator units
  localparam logic signed [ACC_W-1:0] DT_X   = ACC_W'(DT_US);
  localparam logic signed [ACC_W-1:0] MM_DIV = ACC_W'(64'd1_000_000_000_000);
  localparam logic signed [63:0]      DV     = 64'(GRAVITY * DT_US);

  phase_t                   state, state_n;
  logic signed [ACC_W-1:0]  acc, acc_n;
  logic signed [63:0]       v, v_n;
  logic signed [63:0]       max_n;
  logic                     apogee_n;

  logic [64:0]              vel_ext;
  logic signed [63:0]       v_burn;
  logic signed [63:0]       v_grav;
  logic signed [ACC_W-1:0]  acc_burn;
  logic signed [ACC_W-1:0]  acc_grav;
  logic signed [63:0]       alt_now;

  function automatic logic signed [ACC_W-1:0] step_of(input logic signed [63:0] vel);
    logic signed [ACC_W-1:0] vel_x;
    vel_x = $signed({{(ACC_W-64){vel[63]}}, vel});
    return vel_x * DT_X;
  endfunction

  assign vel_ext  = {1'b0, velocity};
  assign v_burn   = backward ? 64'(-vel_ext) : 64'(vel_ext);
  assign v_grav   = v - DV;
  assign acc_burn = acc + step_of(v_burn);
  assign acc_grav = acc + step_of(v_grav);
  assign alt_now  = 64'(acc / MM_DIV);

  always_comb begin
    state_n  = state;
    acc_n    = acc;
    v_n      = v;
    max_n    = max_altitude_mm;
    apogee_n = 1'b0;
    case (state)
      IDLE: begin
        acc_n = '0;
        v_n   = '0;
        if (start) state_n = BURN;
      end
      BURN: begin
        v_n   = v_burn;
        acc_n = (acc_burn < 0) ? '0 : acc_burn;
        if (ignition_end) state_n = COAST;
      end
      COAST: begin
        v_n   = v_grav;
        acc_n = acc_grav;
        // peak is the altitude before the step that turns velocity non-positive
        if (v_grav <= 0) begin
          state_n  = DESCENT;
          apogee_n = 1'b1;
          max_n    = alt_now;
        end
      end
      DESCENT: begin
        if (acc_grav <= 0) begin
          acc_n   = '0;
          v_n     = '0;
          state_n = LANDED;
        end else begin
          v_n   = v_grav;
          acc_n = acc_grav;
        end
      end
      LANDED: begin
        state_n = LANDED;
      end
      default: begin
        state_n = IDLE;
        acc_n   = '0;
        v_n     = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      acc             <= '0;
      v               <= '0;
      altitude_mm     <= '0;
      max_altitude_mm <= '0;
      apogee          <= 1'b0;
    end else begin
      state           <= state_n;
      acc             <= acc_n;
      v               <= v_n;
      altitude_mm     <= alt_now;
      max_altitude_mm <= max_n;
      apogee          <= apogee_n;
    end
  end

  assign vert_velocity = v;
  assign phase         = state;
  assign landed        = (state == LANDED);

endmodule
